lc3b_mem_access_ctrl: RTL
=========================

Name: lc3b_mem_access_ctrl

Overview:
Sequencer for LC-3b load/store instructions (LDB, LDW, STB, STW). It drives the select inputs of the shared address adder and latches the adder result into MAR. It runs a ready-handshake transaction with a multi-cycle memory, formats load data and store byte lanes, and flags unaligned word accesses and memory timeouts. It sits between instruction decode and the memory port, alongside the address adder.

Parameters:
TIMEOUT, 16, max cycles waiting in MEM for mem_ready before aborting; legal range 1..255
TO_W, 8, width of the timeout counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request to execute the instruction on IR; sampled in IDLE only
IR  in  16  instruction word; latched on accepted start
SR  in  16  store data (register file SR); latched on accepted start
ADDR_OUT  in  16  result of the address adder
ADDR1_SEL  out  2  to address adder; 0 = PC, 1 = BaseR
ADDR2_SEL  out  3  to address adder; 0 = zero, 1 = offset6
LSHFT  out  1  to address adder; offset left shift
IR_OUT  out  16  latched IR, fed to the adder IR input
mem_en  out  1  memory request
mem_we  out  1  write enable
mem_wmask  out  2  byte lane enables; [1] = high byte, [0] = low byte
MAR  out  16  memory address register
mem_wdata  out  16  write data
mem_rdata  in  16  read data; valid when mem_ready = 1
mem_ready  in  1  memory completion (R signal)
load_data  out  16  formatted load result; valid while done = 1
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle abort pulse
err_code  out  2  01 = unaligned, 10 = timeout, 11 = illegal opcode; held until the next accepted start

Behaviour:
- Reset (synchronous, active-high): state = IDLE. All outputs are 0, including MAR, load_data and err_code. Reset has priority over every other input.
- Reset mid-transaction: mem_en drops on the same edge, and no done or err pulse is issued.
- States: IDLE, CALC, MEM, FMT, DONE, ERR.
- IDLE:
  - Adder selects are 0/0/0.
  - On start = 1, latch IR and SR, then decode IR[15:12]: 0010 = LDB, 0110 = LDW, 0011 = STB, 0111 = STW.
  - Any other opcode goes to ERR with err_code = 11.
  - Otherwise go to CALC.
- CALC (exactly 1 cycle):
  - Drive ADDR1_SEL = 1, ADDR2_SEL = 1, LSHFT = 1 for word ops and 0 for byte ops.
  - At the end of the cycle, MAR <= ADDR_OUT.
  - If the op is a word op and ADDR_OUT[0] = 1, go to ERR with err_code = 01. No memory request is made.
  - Otherwise go to MEM.
- MEM:
  - mem_en = 1. mem_we = 1 for stores.
  - The timeout counter clears on entry and increments each cycle mem_ready = 0.
  - On mem_ready = 1: loads capture mem_rdata and go to FMT; stores go to DONE.
  - If the counter reaches TIMEOUT with mem_ready still 0, go to ERR with err_code = 10.
  - mem_ready in the same cycle as the limit counts as success.
- Store formatting:
  - STW: mem_wdata = SR, mem_wmask = 11.
  - STB: mem_wdata = {SR[7:0], SR[7:0]}, mem_wmask = 10 if MAR[0] = 1, else 01.
- FMT:
  - LDW: load_data = captured word.
  - LDB: select the byte by MAR[0] (1 = high byte) and sign-extend bit 7 to 16 bits.
  - Then go to DONE.
- DONE: done = 1 for 1 cycle, then IDLE. load_data holds its value until the next load completes.
- ERR: err = 1 for 1 cycle, then IDLE.
- Outputs:
  - mem_en, mem_we and mem_wmask are registered and are 0 outside MEM.
  - Adder selects are combinational from the state.
- Latency, counting start-accept as cycle 0 and a zero-wait memory:
  - Stores: done in cycle 3.
  - Loads: done in cycle 4.
  - Each wait cycle adds 1.
- Hazards:
  - start while busy = 1 is ignored.
  - mem_ready outside MEM is ignored.
- Address wrap: 16-bit modulo, inherited from the adder. MAR = 0xFFFF is legal for byte ops.

Test Plan:
The bench instantiates the address adder with SR1 driven by the bench.
- LDW, SR1 = 0x3000, IR offset6 = 2, memory returns 0xBEEF after 2 wait cycles -> MAR = 0x3004, mem_wmask = 00, done in cycle 6, load_data = 0xBEEF.
- LDB, SR1 = 0x3001, offset6 = 0, mem_rdata = 0x80FF, zero wait -> MAR = 0x3001, load_data = 0xFF80, done in cycle 4.
- STB, SR1 = 0x4000, offset6 = -1 (0x3F), SR = 0x12A5 -> MAR = 0x3FFF, mem_wdata = 0xA5A5, mem_wmask = 10, mem_we = 1, done in cycle 3.
- LDW, SR1 = 0x3001, offset6 = 0 -> err pulse in cycle 2, err_code = 01, mem_en never asserted, busy low in cycle 3.
- STW with mem_ready held at 0, TIMEOUT = 16 -> mem_en high for 16 cycles, then err with err_code = 10, mem_en drops.
- LDW with reset asserted in the 2nd MEM cycle -> next cycle: IDLE, mem_en = 0, MAR = 0, no done or err. A new start is accepted in the following cycle.

Source files
------------

// File: rtl/lc3b_mem_access_ctrl.sv
// lc3b_mem_access_ctrl
//   Sequencer for LC-3b LDB/LDW/STB/STW. It steers the shared address adder,
//   latches the effective address into MAR and runs a ready handshake with a
//   multi-cycle memory. It formats load data and store byte lanes, and aborts
//   on unaligned word accesses, on memory timeouts and on illegal opcodes.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   start, IR, SR          request plus instruction and store data (taken in IDLE)
//   ADDR_OUT               adder result
//   ADDR1_SEL, ADDR2_SEL,
//   LSHFT, IR_OUT          adder controls and latched IR
//   mem_en, mem_we,
//   mem_wmask, mem_wdata,
//   MAR                    memory request (mem_en/we/wmask/wdata are registered)
//   mem_rdata, mem_ready   memory response
//   load_data              formatted load result, held until the next load
//   busy, done, err        status; done and err are one-cycle pulses
//   err_code               01 unaligned, 10 timeout, 11 illegal opcode
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start, decode opcode on accept
// CALC  | adder computes BaseR + offset6, result latched into MAR
// MEM   | memory request outstanding, timeout counter running
// FMT   | load data byte select / sign extension
// DONE  | one-cycle done pulse
// ERR   | one-cycle err pulse, err_code already valid
module lc3b_mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] IR,
  input  logic [15:0] SR,
  input  logic [15:0] ADDR_OUT,
  output logic [1:0]  ADDR1_SEL,
  output logic [2:0]  ADDR2_SEL,
  output logic        LSHFT,
  output logic [15:0] IR_OUT,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_wmask,
  output logic [15:0] MAR,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_MEM,
    S_FMT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, next_state;
  logic [15:0]     ir_q, sr_q, mar_q, rdata_q, load_data_q;
  logic [1:0]      err_code_q;
  logic [TO_W-1:0] to_cnt;
  logic            mem_en_q, mem_we_q;
  logic [1:0]      wmask_q;
  logic [15:0]     wdata_q;

  logic            legal_op;
  logic            is_word, is_store;
  logic            addr_lsb;
  logic [1:0]      wmask_nxt;
  logic [15:0]     wdata_nxt;
  logic [7:0]      ld_byte;

  // Opcode classes: 0010 LDB, 0110 LDW, 0011 STB, 0111 STW.
  // IR[14] marks word ops and IR[12] marks stores.
  assign legal_op = ~IR[15] & IR[13];
  assign is_word  = ir_q[14];
  assign is_store = ir_q[12];

  // MAR is only written at the end of CALC, so the lane choice taken on
  // entry to MEM has to look at the adder output directly.
  assign addr_lsb = (state == S_CALC) ? ADDR_OUT[0] : mar_q[0];

  always_comb begin
    wmask_nxt = 2'b00;
    wdata_nxt = 16'h0000;
    if (is_store) begin
      if (is_word) begin
        wmask_nxt = 2'b11;
        wdata_nxt = sr_q;
      end else begin
        wmask_nxt = addr_lsb ? 2'b10 : 2'b01;
        wdata_nxt = {sr_q[7:0], sr_q[7:0]};
      end
    end
  end

  assign ld_byte = mar_q[0] ? rdata_q[15:8] : rdata_q[7:0];

  always_comb begin
    next_state = state;
    ADDR1_SEL  = 2'd0;
    ADDR2_SEL  = 3'd0;
    LSHFT      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = legal_op ? S_CALC : S_ERR;
      end
      S_CALC: begin
        ADDR1_SEL  = 2'd1;
        ADDR2_SEL  = 3'd1;
        LSHFT      = is_word;
        next_state = (is_word && ADDR_OUT[0]) ? S_ERR : S_MEM;
      end
      S_MEM: begin
        if (mem_ready)              next_state = is_store ? S_DONE : S_FMT;
        else if (to_cnt == TO_LAST) next_state = S_ERR;
      end
      S_FMT:   next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ir_q        <= '0;
      sr_q        <= '0;
      mar_q       <= '0;
      rdata_q     <= '0;
      load_data_q <= '0;
      err_code_q  <= '0;
      to_cnt      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      wmask_q     <= 2'b00;
      wdata_q     <= '0;
    end else begin
      state <= next_state;

      // Memory-side outputs are valid exactly while the state is MEM.
      if (next_state == S_MEM) begin
        mem_en_q <= 1'b1;
        mem_we_q <= is_store;
        wmask_q  <= wmask_nxt;
        wdata_q  <= wdata_nxt;
      end else begin
        mem_en_q <= 1'b0;
        mem_we_q <= 1'b0;
        wmask_q  <= 2'b00;
        wdata_q  <= '0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            ir_q       <= IR;
            sr_q       <= SR;
            err_code_q <= legal_op ? 2'b00 : 2'b11;
          end
        end
        S_CALC: begin
          mar_q  <= ADDR_OUT;
          to_cnt <= '0;
          if (is_word && ADDR_OUT[0]) err_code_q <= 2'b01;
        end
        S_MEM: begin
          if (mem_ready)              rdata_q    <= mem_rdata;
          else if (to_cnt == TO_LAST) err_code_q <= 2'b10;
          else                        to_cnt     <= to_cnt + 1'b1;
        end
        S_FMT: begin
          load_data_q <= is_word ? rdata_q : {{8{ld_byte[7]}}, ld_byte};
        end
        default: ;
      endcase
    end
  end

  assign IR_OUT    = ir_q;
  assign MAR       = mar_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;
  assign load_data = load_data_q;
  assign err_code  = err_code_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);

endmodule
